// File: rtl/register_uart_pkg.sv
// Shared definitions for the register-mapped UART: register offsets, status bit
// positions and the TX/RX state encodings.
package register_uart_pkg;

   localparam int DATA_OFFSET   = 0;
   localparam int STATUS_OFFSET = 1;

   localparam int ST_TX_FULL       = 0;
   localparam int ST_TX_EMPTY      = 1;
   localparam int ST_RX_VALID      = 2;
   localparam int ST_TX_OVERFLOW   = 3;
   localparam int ST_RX_OVERRUN    = 4;
   localparam int ST_RX_FRAME_ERR  = 5;

   // Sticky bits are kept as a 3-bit vector in status order (overflow, overrun, frame error).
   localparam int STICKY_BITS = 3;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   function automatic logic [15:0] pack_status(
      input logic                   tx_full,
      input logic                   tx_empty,
      input logic                   rx_valid,
      input logic [STICKY_BITS-1:0] sticky
   );
      logic [15:0] s;
      s                  = '0;
      s[ST_TX_FULL]      = tx_full;
      s[ST_TX_EMPTY]     = tx_empty;
      s[ST_RX_VALID]     = rx_valid;
      s[ST_TX_OVERFLOW]  = sticky[0];
      s[ST_RX_OVERRUN]   = sticky[1];
      s[ST_RX_FRAME_ERR] = sticky[2];
      return s;
   endfunction

endpackage

// File: rtl/register_uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is visible combinationally so
// a pop and the consumption of its data happen in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/register_uart.sv
// Register-mapped 8N1 UART: data register feeds TX FIFO / drains RX FIFO,
// status register reports FIFO state and clear-on-read error flags.
module register_uart
   import register_uart_pkg::*;
#(
   parameter int BASE_INDEX     = 0,
   parameter int FIFO_DEPTH     = 8,
   parameter int CLOCKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  register_index,
   input  logic        register_read,
   input  logic        register_write,
   input  logic [15:0] register_write_value,
   output logic [15:0] register_read_value,
   output logic        uart_tx,
   input  logic        uart_rx
);

   localparam logic [6:0] DATA_INDEX   = 7'(BASE_INDEX + DATA_OFFSET);
   localparam logic [6:0] STATUS_INDEX = 7'(BASE_INDEX + STATUS_OFFSET);
   localparam int         CW           = $clog2(CLOCKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);

   logic sel_data;
   logic sel_status;
   logic data_read;
   logic data_write;
   logic status_read;

   logic       tx_pop;
   logic [7:0] tx_head;
   logic       tx_full;
   logic       tx_fifo_empty;
   logic [7:0] rx_head;
   logic       rx_full;
   logic       rx_empty;

   tx_state_t     tx_state_reg;
   logic [CW-1:0] tx_cnt_reg;
   logic [2:0]    tx_bit_reg;
   logic [7:0]    tx_shift_reg;

   logic          rx_meta_reg;
   logic          rx_sync_reg;
   logic          rx_sync_d_reg;
   rx_state_t     rx_state_reg;
   logic [CW-1:0] rx_cnt_reg;
   logic [2:0]    rx_bit_reg;
   logic [7:0]    rx_shift_reg;
   logic          rx_stop_wait_reg;
   logic          rx_done_reg;
   logic          rx_ferr_reg;

   logic [STICKY_BITS-1:0] sticky_reg;
   logic [STICKY_BITS-1:0] sticky_event;
   logic [15:0]            status_word;
   logic                   unused_high_bits;

   assign sel_data    = (register_index == DATA_INDEX);
   assign sel_status  = (register_index == STATUS_INDEX);
   assign data_read   = register_read && sel_data;
   assign data_write  = register_write && sel_data;
   assign status_read = register_read && sel_status;
   assign unused_high_bits = ^register_write_value[15:8];

   assign tx_pop = (tx_state_reg == TX_IDLE) && !tx_fifo_empty;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (data_write),
      .push_data (register_write_value[7:0]),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_fifo_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (rx_done_reg),
      .push_data (rx_shift_reg),
      .pop       (data_read),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   // Transmitter: the shifter moves right so the next data bit is always at [1].
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_state_reg <= TX_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= '0;
         tx_shift_reg <= '0;
         uart_tx      <= 1'b1;
      end else begin
         case (tx_state_reg)
            TX_IDLE: begin
               if (!tx_fifo_empty) begin
                  tx_shift_reg <= tx_head;
                  tx_cnt_reg   <= '0;
                  uart_tx      <= 1'b0;
                  tx_state_reg <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg   <= '0;
                  tx_bit_reg   <= '0;
                  uart_tx      <= tx_shift_reg[0];
                  tx_state_reg <= TX_DATA;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
            TX_DATA: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg <= '0;
                  if (tx_bit_reg == 3'd7) begin
                     uart_tx      <= 1'b1;
                     tx_state_reg <= TX_STOP;
                  end else begin
                     tx_bit_reg   <= tx_bit_reg + 1'b1;
                     uart_tx      <= tx_shift_reg[1];
                     tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
                  end
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_cnt_reg == BIT_LAST) begin
                  tx_cnt_reg   <= '0;
                  tx_state_reg <= TX_IDLE;
               end else begin
                  tx_cnt_reg <= tx_cnt_reg + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta_reg   <= 1'b1;
         rx_sync_reg   <= 1'b1;
         rx_sync_d_reg <= 1'b1;
      end else begin
         rx_meta_reg   <= uart_rx;
         rx_sync_reg   <= rx_meta_reg;
         rx_sync_d_reg <= rx_sync_reg;
      end
   end

   // Receiver: counts restart at each sample point, so after the half-bit start
   // sample every later sample lands one full bit later, i.e. at mid-bit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_state_reg     <= RX_IDLE;
         rx_cnt_reg       <= '0;
         rx_bit_reg       <= '0;
         rx_shift_reg     <= '0;
         rx_stop_wait_reg <= 1'b0;
         rx_done_reg      <= 1'b0;
         rx_ferr_reg      <= 1'b0;
      end else begin
         rx_done_reg <= 1'b0;
         rx_ferr_reg <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               rx_cnt_reg <= '0;
               if (rx_sync_d_reg && !rx_sync_reg) rx_state_reg <= RX_START;
            end
            RX_START: begin
               if (rx_cnt_reg == HALF_LAST) begin
                  rx_cnt_reg   <= '0;
                  rx_bit_reg   <= '0;
                  rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt_reg == BIT_LAST) begin
                  rx_cnt_reg   <= '0;
                  rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                  if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
                  else rx_bit_reg <= rx_bit_reg + 1'b1;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 1'b1;
               end
            end
            RX_STOP: begin
               if (!rx_stop_wait_reg) begin
                  if (rx_cnt_reg == BIT_LAST) begin
                     rx_cnt_reg <= '0;
                     if (rx_sync_reg) begin
                        rx_done_reg  <= 1'b1;
                        rx_state_reg <= RX_IDLE;
                     end else begin
                        rx_ferr_reg      <= 1'b1;
                        rx_stop_wait_reg <= 1'b1;
                     end
                  end else begin
                     rx_cnt_reg <= rx_cnt_reg + 1'b1;
                  end
               end else if (rx_cnt_reg == HALF_LAST) begin
                  // Sit out the rest of a bad stop bit before hunting for a new start.
                  rx_cnt_reg       <= '0;
                  rx_stop_wait_reg <= 1'b0;
                  rx_state_reg     <= RX_IDLE;
               end else begin
                  rx_cnt_reg <= rx_cnt_reg + 1'b1;
               end
            end
         endcase
      end
   end

   assign sticky_event[0] = data_write && tx_full && !tx_pop;
   assign sticky_event[1] = rx_done_reg && rx_full && !(data_read && !rx_empty);
   assign sticky_event[2] = rx_ferr_reg;

   assign status_word = pack_status(tx_full, tx_fifo_empty && (tx_state_reg == TX_IDLE),
                                    !rx_empty, sticky_reg);

   genvar gi;
   generate
      for (gi = 0; gi < STICKY_BITS; gi++) begin : g_sticky
         always_ff @(posedge clk) begin
            if (!reset_n) sticky_reg[gi] <= 1'b0;
            else sticky_reg[gi] <= (sticky_reg[gi] && !status_read) || sticky_event[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         register_read_value <= '0;
      end else if (register_read) begin
         if (sel_data)        register_read_value <= rx_empty ? 16'h0000 : {8'h00, rx_head};
         else if (sel_status) register_read_value <= status_word;
         else                 register_read_value <= 16'h0000;
      end
   end

endmodule

// File: tb/tb_register_uart.sv
// Bench for register_uart: transaction-level model (queues + frame timing arithmetic)
// compared every cycle, plus literal expectations posted by the directed sequences.
module tb_register_uart;

   localparam int CPB   = 4;
   localparam int DEPTH = 8;
   localparam int BASE  = 0;
   localparam logic [6:0] DATA_IDX   = 7'(BASE);
   localparam logic [6:0] STATUS_IDX = 7'(BASE + 1);

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [6:0]  register_index = '0;
   logic        register_read = 1'b0;
   logic        register_write = 1'b0;
   logic [15:0] register_write_value = '0;
   logic [15:0] register_read_value;
   logic        uart_tx;
   logic        uart_rx = 1'b1;

   register_uart #(.BASE_INDEX(BASE), .FIFO_DEPTH(DEPTH), .CLOCKS_PER_BIT(CPB)) dut (
      .clk                  (clk),
      .reset_n              (reset_n),
      .register_index       (register_index),
      .register_read        (register_read),
      .register_write       (register_write),
      .register_write_value (register_write_value),
      .register_read_value  (register_read_value),
      .uart_tx              (uart_tx),
      .uart_rx              (uart_rx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model state, owned by model_step.
   longint     cyc = 0;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];
   logic       have_frame = 1'b0;
   longint     frame_p = 0;
   logic [7:0] frame_byte = '0;
   logic       m_ovf = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;
   logic [15:0] exp_rd = '0;
   logic       exp_tx = 1'b1;
   logic       m_init = 1'b0;
   int         rx_seen = 0;

   // Posted by stimulus only.
   int         rx_evt_seq = 0;
   logic [7:0] rx_evt_byte = '0;
   logic       rx_evt_ok = 1'b1;
   int         lit_wr = 0;
   logic       lit_kind[512];
   logic [15:0] lit_exp[512];
   string      lit_name[512];
   int         lit_rd = 0;

   task automatic model_step();
      logic        idle;
      logic        is_data, is_stat;
      logic [15:0] status;
      logic        ovf_e, ovr_e, fe_e;
      longint      off;
      int          b;
      cyc++;
      if (!reset_n) begin
         tx_q.delete();
         rx_q.delete();
         have_frame = 1'b0;
         m_ovf = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
         exp_rd = 16'h0000;
         exp_tx = 1'b1;
         rx_seen = rx_evt_seq;
         m_init = 1'b1;
         return;
      end
      // A frame popped at edge p occupies 10*CPB cycles; the transmitter is idle afterwards.
      idle    = !have_frame || (cyc - frame_p > 10 * CPB);
      is_data = (register_index == DATA_IDX);
      is_stat = (register_index == STATUS_IDX);
      status  = {10'd0, m_fe, m_ovr, m_ovf, rx_q.size() != 0,
                 (tx_q.size() == 0) && idle, tx_q.size() == DEPTH};
      ovf_e = 1'b0; ovr_e = 1'b0; fe_e = 1'b0;
      if (register_read) begin
         if (is_data) exp_rd = (rx_q.size() != 0) ? {8'h00, rx_q.pop_front()} : 16'h0000;
         else if (is_stat) exp_rd = status;
         else exp_rd = 16'h0000;
      end
      if (idle && tx_q.size() != 0) begin
         frame_byte = tx_q.pop_front();
         frame_p    = cyc;
         have_frame = 1'b1;
      end
      if (register_write && is_data) begin
         if (tx_q.size() < DEPTH) tx_q.push_back(register_write_value[7:0]);
         else ovf_e = 1'b1;
      end
      if (rx_evt_seq != rx_seen) begin
         rx_seen = rx_evt_seq;
         if (!rx_evt_ok) fe_e = 1'b1;
         else if (rx_q.size() < DEPTH) rx_q.push_back(rx_evt_byte);
         else ovr_e = 1'b1;
      end
      if (register_read && is_stat) begin
         m_ovf = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
      end
      m_ovf = m_ovf | ovf_e;
      m_ovr = m_ovr | ovr_e;
      m_fe  = m_fe  | fe_e;
      off = cyc - frame_p;
      if (have_frame && off >= 0 && off < 10 * CPB) begin
         b = int'(off) / CPB;
         if (b == 0) exp_tx = 1'b0;
         else if (b == 9) exp_tx = 1'b1;
         else exp_tx = frame_byte[b-1];
      end else begin
         exp_tx = 1'b1;
      end
   endtask

   always @(posedge clk) model_step();

   always @(negedge clk) begin
      logic [15:0] act;
      if (m_init) begin
         checks++;
         if (register_read_value !== exp_rd) begin
            failures++;
            if (failures < 50) $display("FAIL read_value cyc=%0d got=%h required=%h", cyc, register_read_value, exp_rd);
         end
         checks++;
         if (uart_tx !== exp_tx) begin
            failures++;
            if (failures < 50) $display("FAIL uart_tx cyc=%0d got=%b required=%b", cyc, uart_tx, exp_tx);
         end
      end
      while (lit_rd != lit_wr) begin
         act = lit_kind[lit_rd % 512] ? {15'd0, uart_tx} : register_read_value;
         checks++;
         if (act !== lit_exp[lit_rd % 512]) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h required=%h", lit_name[lit_rd % 512], cyc, act, lit_exp[lit_rd % 512]);
         end
         lit_rd++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic post(input logic kind, input logic [15:0] exp, input string name);
      lit_kind[lit_wr % 512] = kind;
      lit_exp[lit_wr % 512]  = exp;
      lit_name[lit_wr % 512] = name;
      lit_wr++;
   endtask

   task automatic access(input logic rd, input logic wr, input logic [6:0] idx, input logic [15:0] val);
      register_index       = idx;
      register_write_value = val;
      register_read        = rd;
      register_write       = wr;
      step();
      register_read  = 1'b0;
      register_write = 1'b0;
      $display("txn cyc=%0d rd=%0b wr=%0b idx=%0d wval=%h", cyc, rd, wr, idx, val);
   endtask

   task automatic reg_read(input logic [6:0] idx, input logic [15:0] exp, input string name);
      access(1'b1, 1'b0, idx, 16'h0000);
      post(1'b0, exp, name);
   endtask

   task automatic rx_send(input logic [7:0] data, input logic stop_ok);
      logic [9:0] frame;
      frame = {stop_ok, data, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = frame[i];
         repeat (CPB) step();
      end
      uart_rx = 1'b1;
      repeat (6) step();
      rx_evt_byte = data;
      rx_evt_ok   = stop_ok;
      rx_evt_seq++;
      step();
      $display("txn cyc=%0d rx_frame byte=%h stop_ok=%0b", cyc, data, stop_ok);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  pat;
      logic [7:0]  rx_bytes[9];
      int          r;

      repeat (3) step();
      post(1'b0, 16'h0000, "reset_read_value");
      post(1'b1, 16'h0001, "reset_uart_tx");
      reset_n = 1'b1;
      step();

      // 0x41 framed 8N1, LSB first, one entry per bit.
      pat = 10'b1010000010;
      access(1'b0, 1'b1, DATA_IDX, 16'h1241);
      step();
      for (int i = 0; i < 10 * CPB; i++) begin
         post(1'b1, {15'd0, pat[i / CPB]}, "tx_wave_0x41");
         step();
      end
      repeat (5) step();

      access(1'b0, 1'b1, DATA_IDX, 16'h005A);
      repeat (15) step();
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      post(1'b1, 16'h0001, "tx_high_after_reset");
      reg_read(STATUS_IDX, 16'h0002, "status_after_reset");

      rx_send(8'hA5, 1'b1);
      reg_read(STATUS_IDX, 16'h0006, "status_rx_valid");
      reg_read(DATA_IDX, 16'h00A5, "rx_data_a5");
      reg_read(DATA_IDX, 16'h0000, "rx_data_empty");

      uart_rx = 1'b0;
      step();
      uart_rx = 1'b1;
      repeat (20) step();
      reg_read(STATUS_IDX, 16'h0002, "status_after_glitch");
      rx_send(8'h3C, 1'b0);
      reg_read(STATUS_IDX, 16'h0022, "status_frame_error");
      reg_read(STATUS_IDX, 16'h0002, "status_ferr_cleared");

      for (int i = 0; i < 9; i++) access(1'b0, 1'b1, DATA_IDX, {8'($urandom), 8'(8'h10 + i)});
      reg_read(STATUS_IDX, 16'h0001, "status_nine_writes");
      for (int i = 0; i < 10; i++) access(1'b0, 1'b1, DATA_IDX, {8'h00, 8'(8'h80 + i)});
      reg_read(STATUS_IDX, 16'h0009, "status_tx_overflow");
      reg_read(STATUS_IDX, 16'h0001, "status_overflow_cleared");
      repeat (9 * (10 * CPB + 1) + 20) step();
      reg_read(STATUS_IDX, 16'h0002, "status_tx_drained");

      for (int i = 0; i < 9; i++) begin
         rx_bytes[i] = 8'($urandom);
         rx_send(rx_bytes[i], 1'b1);
      end
      reg_read(STATUS_IDX, 16'h0016, "status_rx_overrun");
      for (int i = 0; i < 8; i++) reg_read(DATA_IDX, {8'h00, rx_bytes[i]}, "rx_fifo_order");
      reg_read(DATA_IDX, 16'h0000, "rx_fifo_drained");

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         if (r < 30)      access(1'b0, 1'b1, DATA_IDX, 16'($urandom));
         else if (r < 45) access(1'b1, 1'b0, DATA_IDX, 16'h0000);
         else if (r < 60) access(1'b1, 1'b0, STATUS_IDX, 16'h0000);
         else if (r < 65) access(1'b1, 1'b0, 7'($urandom_range(2, 127)), 16'h0000);
         else if (r < 70) access(1'b0, 1'b1, ($urandom_range(0, 1) != 0) ? STATUS_IDX : 7'($urandom_range(2, 127)), 16'($urandom));
         else if (r < 74) access(1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? STATUS_IDX : DATA_IDX, 16'($urandom));
         else if (r < 84) rx_send(8'($urandom), $urandom_range(0, 9) != 0);
         else if (r < 85) begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            $display("txn cyc=%0d reset", cyc);
         end else begin
            repeat ($urandom_range(1, 20)) step();
         end
      end

      repeat (50) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/register_uart.md
REGISTER_UART -- requirements
Module: register_uart

Interface
REQ-001 Parameter BASE_INDEX, default 0: register_index of the data register; status register is at BASE_INDEX+1.
REQ-002 Parameter FIFO_DEPTH, default 8: entries per TX and RX FIFO; power of two, minimum 2.
REQ-003 Parameter CLOCKS_PER_BIT, default 16: clk cycles per serial bit; even, minimum 4.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 register_index  input  7  register select from core.
REQ-007 register_read  input  1  read strobe, one cycle per access.
REQ-008 register_write  input  1  write strobe, one cycle per access.
REQ-009 register_write_value  input  16  write data.
REQ-010 register_read_value  output  16  read data.
REQ-011 uart_tx  output  1  serial out, 8N1, idle high.
REQ-012 uart_rx  input  1  serial in, 8N1, asynchronous to clk.

Function
REQ-013 Write to data register pushes register_write_value[7:0] into TX FIFO; bits [15:8] ignored.
REQ-014 Write to data register with TX FIFO full is dropped and sets sticky tx_overflow.
REQ-015 Read of data register pops RX FIFO; register_read_value = {8'h00, byte} on the following cycle.
REQ-016 Read of data register with RX FIFO empty returns 16'h0000 and pops nothing.
REQ-017 Status register read value: bit0 tx_full, bit1 tx_empty (FIFO empty and transmitter idle), bit2 rx_valid, bit3 tx_overflow, bit4 rx_overrun, bit5 rx_frame_error, bits [15:6] zero.
REQ-018 Status read returns the sticky bits and clears bits 3-5 in the same cycle; an error event in that cycle stays set.
REQ-019 Read latency exactly one cycle; register_read_value holds its value until the next read; reads of non-decoded indices return 16'h0000.
REQ-020 Writes to status register and accesses to indices outside BASE_INDEX..BASE_INDEX+1 have no effect.
REQ-021 Simultaneous push and pop on one FIFO both take effect; occupancy unchanged; full FIFO accepts a push when popped the same cycle.
REQ-022 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full = MSBs differ, lower bits equal.
REQ-023 TX states IDLE, START, DATA, STOP; IDLE pops the FIFO when non-empty and enters START the next cycle.
REQ-024 Each TX bit lasts exactly CLOCKS_PER_BIT cycles: start 0, data LSB first, stop 1; STOP returns to IDLE, giving back-to-back frames of 10*CLOCKS_PER_BIT cycles plus at most 1 idle cycle.
REQ-025 uart_rx passes through a 2-flop synchronizer before any use.
REQ-026 RX states IDLE, START, DATA, STOP; falling edge of synchronized input in IDLE enters START.
REQ-027 START samples at CLOCKS_PER_BIT/2; high sample returns to IDLE (glitch rejection), no error.
REQ-028 DATA samples each bit at mid-bit, LSB first; STOP samples once at mid-bit.
REQ-029 Stop sample low: byte discarded, rx_frame_error set, return to IDLE after the stop bit period.
REQ-030 Valid byte with RX FIFO full: byte discarded, rx_overrun set.

Reset
REQ-031 While reset_n low at a clk edge: FIFOs empty, sticky bits 0, both FSMs IDLE, uart_tx 1, register_read_value 16'h0000.
REQ-032 Reset mid-frame aborts the frame immediately; uart_tx is 1 the cycle after the reset edge; partial RX byte discarded.

Structure
REQ-033 Shared package register_uart_pkg holds register offsets, status bit positions and FSM state encodings.
REQ-034 FIFO is sub-module sync_fifo (parameters WIDTH, DEPTH), instantiated twice with WIDTH=8.

Verification
REQ-035 CLOCKS_PER_BIT=4: write 16'h1241 -> uart_tx shows 0,1,0,0,0,0,0,1,0,1, each 4 cycles.
REQ-036 Write 9 bytes at FIFO_DEPTH=8 back-to-back while TX idle -> first byte popped into shifter, all 9 transmitted, tx_overflow 0; write 10 more -> status bit3 1, second status read bit3 0.
REQ-037 Drive frame 8'hA5 on uart_rx -> status bit2 1, data read returns 16'h00A5, next data read 16'h0000.
REQ-038 uart_rx low pulse of 1 cycle -> no byte, no error; frame with stop bit 0 -> status bit5 1, rx_valid 0.
REQ-039 Assert reset_n low mid-TX-frame for one cycle -> uart_tx 1 next cycle, status reads 16'h0002.
REQ-040 Fill RX FIFO with 8 bytes, send a 9th -> status bit4 1, reads return first 8 bytes in order.
